// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings, default geometry and derived edges for the Pong engine
package pong_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int DEF_CANVAS_TOP     = 50;
  localparam int DEF_CANVAS_BOTTOM  = 450;
  localparam int DEF_CANVAS_LEFT    = 50;
  localparam int DEF_CANVAS_RIGHT   = 600;
  localparam int DEF_BALL_SIZE      = 10;
  localparam int DEF_PADDLE_OFFSET  = 20;
  localparam int DEF_PADDLE_W       = 10;
  localparam int DEF_PADDLE_H       = 50;
  localparam int DEF_PADDLE_SPEED   = 4;
  localparam int DEF_BALL_SPEED     = 2;
  localparam int DEF_BALL_SPEED_MAX = 6;
  localparam int DEF_SCORE_W        = 4;
  localparam int DEF_WIN_SCORE      = 9;
  localparam int DEF_SERVE_FRAMES   = 60;

  function automatic logic [9:0] centre(int lo, int hi, int size);
    return 10'((lo + hi - size) / 2);
  endfunction

  // Inner faces of the paddles: the x a ball edge must reach to be returned
  function automatic logic [9:0] edge_l(int left, int offset, int width);
    return 10'(left + offset + width);
  endfunction

  function automatic logic [9:0] edge_r(int right, int offset, int width);
    return 10'(right - offset - width);
  endfunction

  localparam logic [9:0] DEF_EDGE_L = edge_l(DEF_CANVAS_LEFT, DEF_PADDLE_OFFSET, DEF_PADDLE_W);
  localparam logic [9:0] DEF_EDGE_R = edge_r(DEF_CANVAS_RIGHT, DEF_PADDLE_OFFSET, DEF_PADDLE_W);
  localparam logic [9:0] DEF_BALL_X0 = centre(DEF_CANVAS_LEFT, DEF_CANVAS_RIGHT, DEF_BALL_SIZE);
  localparam logic [9:0] DEF_BALL_Y0 = centre(DEF_CANVAS_TOP, DEF_CANVAS_BOTTOM, DEF_BALL_SIZE);
  localparam logic [9:0] DEF_PAD_Y0  = centre(DEF_CANVAS_TOP, DEF_CANVAS_BOTTOM, DEF_PADDLE_H);

endpackage

// File: rtl/pong_paddle_ctrl.sv
// rtl/pong_paddle_ctrl.sv - one paddle: move by SPEED per frame on {up, down}, clamped to the playfield
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int TOP    = DEF_CANVAS_TOP,
  parameter int BOTTOM = DEF_CANVAS_BOTTOM,
  parameter int HEIGHT = DEF_PADDLE_H,
  parameter int SPEED  = DEF_PADDLE_SPEED
) (
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] buttons,
  output logic [9:0] y
);

  localparam logic [9:0] Y_MIN = 10'(TOP);
  localparam logic [9:0] Y_MAX = 10'(BOTTOM - HEIGHT);
  localparam logic [9:0] Y_RST = centre(TOP, BOTTOM, HEIGHT);
  localparam logic [9:0] STEP  = 10'(SPEED);

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      y <= Y_RST;
    end else if (enable) begin
      case (buttons)
        2'b10:   y <= (y < Y_MIN + STEP) ? Y_MIN : y - STEP;
        2'b01:   y <= (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
        default: y <= y;
      endcase
    end
  end

endmodule

// File: rtl/pong_frame_engine.sv
// rtl/pong_frame_engine.sv - per-frame Pong physics, scoring and game state machine
// Define PONG_BALL_SPEEDUP_EN to raise the ball speed on every 4th paddle hit since the serve.
module pong_frame_engine
  import pong_pkg::*;
#(
  parameter int CANVAS_TOP     = DEF_CANVAS_TOP,
  parameter int CANVAS_BOTTOM  = DEF_CANVAS_BOTTOM,
  parameter int CANVAS_LEFT    = DEF_CANVAS_LEFT,
  parameter int CANVAS_RIGHT   = DEF_CANVAS_RIGHT,
  parameter int BALL_SIZE      = DEF_BALL_SIZE,
  parameter int PADDLE_OFFSET  = DEF_PADDLE_OFFSET,
  parameter int PADDLE_W       = DEF_PADDLE_W,
  parameter int PADDLE_H       = DEF_PADDLE_H,
  parameter int PADDLE_SPEED   = DEF_PADDLE_SPEED,
  parameter int BALL_SPEED     = DEF_BALL_SPEED,
  parameter int BALL_SPEED_MAX = DEF_BALL_SPEED_MAX,
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int WIN_SCORE      = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES
) (
  input  logic               frame_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         left_in,
  input  logic [1:0]         right_in,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         pad_l_y,
  output logic [9:0]         pad_r_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         state,
  output logic               running,
  output logic               game_over
);

  localparam logic [9:0] CT = 10'(CANVAS_TOP);
  localparam logic [9:0] CB = 10'(CANVAS_BOTTOM);
  localparam logic [9:0] CL = 10'(CANVAS_LEFT);
  localparam logic [9:0] CR = 10'(CANVAS_RIGHT);
  localparam logic [9:0] BS = 10'(BALL_SIZE);
  localparam logic [9:0] PH = 10'(PADDLE_H);
  localparam logic [9:0] EL = edge_l(CANVAS_LEFT, PADDLE_OFFSET, PADDLE_W);
  localparam logic [9:0] ER = edge_r(CANVAS_RIGHT, PADDLE_OFFSET, PADDLE_W);
  localparam logic [9:0] X0 = centre(CANVAS_LEFT, CANVAS_RIGHT, BALL_SIZE);
  localparam logic [9:0] Y0 = centre(CANVAS_TOP, CANVAS_BOTTOM, BALL_SIZE);
  // A misconfigured ceiling below the serve speed caps the serve speed too
  localparam logic [9:0] SPD_MAX   = 10'(BALL_SPEED_MAX);
  localparam logic [9:0] SPD_START = 10'((BALL_SPEED_MAX < BALL_SPEED) ? BALL_SPEED_MAX : BALL_SPEED);
  localparam int SC_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [SC_W-1:0]    SERVE_LAST = SC_W'(SERVE_FRAMES - 1);
  localparam logic [SC_W-1:0]    SC_ONE     = SC_W'(1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] PT_ONE     = SCORE_W'(1);

  logic            start_q, dir_x, dir_y, left_scored;
  logic [SC_W-1:0] serve_cnt;
  logic [9:0]      speed;
  logic            start_rise, paddle_en, serve_entry, win_now;
  logic            hit_l, hit_r, lost_l, lost_r, ndx, ndy;
  logic [9:0]      nx, ny;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  assign start_rise  = start & ~start_q;
  assign paddle_en   = (state == ST_IDLE) || (state == ST_SERVE) || (state == ST_PLAY);
  assign running     = (state == ST_PLAY);
  assign game_over   = (state == ST_OVER);
  assign score_l_inc = score_l + PT_ONE;
  assign score_r_inc = score_r + PT_ONE;
  assign win_now     = left_scored ? (score_l_inc == WIN) : (score_r_inc == WIN);
  assign serve_entry = ((state == ST_IDLE || state == ST_OVER) && start_rise) ||
                       (state == ST_POINT && !win_now);

  pong_paddle_ctrl #(
    .TOP(CANVAS_TOP), .BOTTOM(CANVAS_BOTTOM), .HEIGHT(PADDLE_H), .SPEED(PADDLE_SPEED)
  ) u_pad_l (
    .frame_clk(frame_clk), .reset(reset), .enable(paddle_en), .buttons(left_in), .y(pad_l_y)
  );

  pong_paddle_ctrl #(
    .TOP(CANVAS_TOP), .BOTTOM(CANVAS_BOTTOM), .HEIGHT(PADDLE_H), .SPEED(PADDLE_SPEED)
  ) u_pad_r (
    .frame_clk(frame_clk), .reset(reset), .enable(paddle_en), .buttons(right_in), .y(pad_r_y)
  );

  // Compare forms are arranged so no subtraction can wrap below zero
  always_comb begin
    ny  = ball_y;
    ndy = dir_y;
    if (!dir_y && ball_y <= CT + speed) begin
      ny  = CT;
      ndy = 1'b1;
    end else if (dir_y && ball_y + speed + BS >= CB) begin
      ny  = CB - BS;
      ndy = 1'b0;
    end else begin
      ny = dir_y ? ball_y + speed : ball_y - speed;
    end

    hit_l = !dir_x && ball_x >= EL && ball_x - speed <= EL &&
            ball_y + BS > pad_l_y && ball_y < pad_l_y + PH;
    hit_r = dir_x && ball_x + BS <= ER && ball_x + BS + speed >= ER &&
            ball_y + BS > pad_r_y && ball_y < pad_r_y + PH;
    lost_l = !hit_l && !hit_r && ball_x <= CL + speed;
    lost_r = !hit_l && !hit_r && !lost_l && ball_x + BS + speed >= CR;

    nx  = ball_x;
    ndx = dir_x;
    if (hit_l) begin
      nx  = EL;
      ndx = 1'b1;
    end else if (hit_r) begin
      nx  = ER - BS;
      ndx = 1'b0;
    end else if (!lost_l && !lost_r) begin
      nx = dir_x ? ball_x + speed : ball_x - speed;
    end
  end

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      ball_x      <= X0;
      ball_y      <= Y0;
      dir_x       <= 1'b0;
      dir_y       <= 1'b1;
      score_l     <= '0;
      score_r     <= '0;
      state       <= ST_IDLE;
      serve_cnt   <= '0;
      start_q     <= 1'b0;
      left_scored <= 1'b0;
    end else begin
      start_q <= start;
      if (serve_entry) begin
        ball_x    <= X0;
        ball_y    <= Y0;
        serve_cnt <= '0;
        state     <= ST_SERVE;
      end
      case (state)
        ST_IDLE: ;
        ST_SERVE: begin
          if (serve_cnt == SERVE_LAST) state <= ST_PLAY;
          else serve_cnt <= serve_cnt + SC_ONE;
        end
        ST_PLAY: begin
          ball_x <= nx;
          ball_y <= ny;
          dir_x  <= ndx;
          dir_y  <= ndy;
          if (lost_l || lost_r) begin
            left_scored <= lost_r;
            state       <= ST_POINT;
          end
        end
        ST_POINT: begin
          if (left_scored) score_l <= score_l_inc;
          else score_r <= score_r_inc;
          // Next serve heads toward whoever conceded
          if (win_now) state <= ST_OVER;
          else dir_x <= left_scored;
        end
        ST_OVER: begin
          if (start_rise) begin
            score_l <= '0;
            score_r <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PONG_BALL_SPEEDUP_EN
  logic [2:0] hit_cnt;

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      speed   <= SPD_START;
      hit_cnt <= 3'd0;
    end else if (serve_entry) begin
      speed   <= SPD_START;
      hit_cnt <= 3'd0;
    end else if (state == ST_PLAY && (hit_l || hit_r)) begin
      hit_cnt <= hit_cnt + 3'd1;
      if (hit_cnt[1:0] == 2'd3 && speed < SPD_MAX) speed <= speed + 10'd1;
    end
  end
`else
  assign speed = SPD_START;
`endif

endmodule

// File: tb/tb_pong_frame_engine.sv
// tb/tb_pong_frame_engine.sv - self-checking bench: vector table, directed rallies, random play vs reference model
module tb_pong_frame_engine;

  localparam int CT = 50, CB = 450, CL = 50, CR = 600, BS = 10;
  localparam int OFF = 20, PW = 10, PH = 50, PS = 4;
  localparam int BSPD = 2, BMAX = 6, WIN = 9, SERVE = 60;
  localparam int X0 = 320, Y0 = 245, P0 = 225;
  localparam int EL = CL + OFF + PW, ER = CR - OFF - PW;
  localparam logic [52:0] RESET_SNAP = {10'd320, 10'd245, 10'd225, 10'd225, 4'd0, 4'd0, 3'd0, 1'b0, 1'b0};

  logic       frame_clk = 1'b0;
  logic       reset, start;
  logic [1:0] left_in, right_in;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic       running, game_over;
  logic [52:0] dut_snap;

  int n_checks = 0;
  int n_fail = 0;

  always #5 frame_clk = ~frame_clk;

  pong_frame_engine dut (
    .frame_clk(frame_clk), .reset(reset), .start(start), .left_in(left_in), .right_in(right_in),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .state(state), .running(running), .game_over(game_over)
  );

  assign dut_snap = {ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, running, game_over};

  // Reference model: game rules on plain integers, states 0..4 = IDLE, SERVE, PLAY, POINT, OVER
  int m_x, m_y, m_pl, m_pr, m_sl, m_sr, m_state, m_dx, m_dy, m_spd, m_cnt, m_hits;
  bit m_sq, m_left_scored;

  function automatic void model_reset();
    m_x = X0; m_y = Y0; m_pl = P0; m_pr = P0; m_sl = 0; m_sr = 0;
    m_state = 0; m_dx = 0; m_dy = 1; m_spd = BSPD; m_cnt = 0; m_hits = 0;
    m_sq = 0; m_left_scored = 0;
  endfunction

  function automatic int pad_move(int y, logic [1:0] b);
    if (b == 2'b10) return (y - PS < CT) ? CT : y - PS;
    if (b == 2'b01) return (y + PS > CB - PH) ? CB - PH : y + PS;
    return y;
  endfunction

  function automatic bit overlap(int by, int py);
    return (by + BS > py) && (by < py + PH);
  endfunction

  function automatic void model_serve();
    m_state = 1; m_cnt = 0; m_x = X0; m_y = Y0; m_spd = BSPD; m_hits = 0;
  endfunction

  function automatic void model_play(int opl, int opr);
    int s = m_spd;
    int ny, ndy;
    bit hit = 0;
    ndy = m_dy;
    if (m_dy == 0) begin
      if (m_y - s <= CT) begin ny = CT; ndy = 1; end else ny = m_y - s;
    end else begin
      if (m_y + BS + s >= CB) begin ny = CB - BS; ndy = 0; end else ny = m_y + s;
    end
    if (m_dx == 0 && m_x >= EL && m_x - s <= EL && overlap(m_y, opl)) begin
      m_x = EL; m_dx = 1; hit = 1;
    end else if (m_dx == 1 && m_x + BS <= ER && m_x + BS + s >= ER && overlap(m_y, opr)) begin
      m_x = ER - BS; m_dx = 0; hit = 1;
    end else if (m_x - s <= CL) begin
      m_left_scored = 0; m_state = 3;
    end else if (m_x + BS + s >= CR) begin
      m_left_scored = 1; m_state = 3;
    end else begin
      m_x = m_dx ? m_x + s : m_x - s;
    end
    m_y = ny; m_dy = ndy;
`ifdef PONG_BALL_SPEEDUP_EN
    if (hit) begin
      m_hits++;
      if (m_hits % 4 == 0 && m_spd < BMAX) m_spd++;
    end
`else
    if (hit) m_hits++;
`endif
  endfunction

  function automatic void model_step(bit st, logic [1:0] li, logic [1:0] ri);
    bit rise = st && !m_sq;
    int opl = m_pl, opr = m_pr;
    m_sq = st;
    if (m_state <= 2) begin
      m_pl = pad_move(m_pl, li);
      m_pr = pad_move(m_pr, ri);
    end
    case (m_state)
      0: if (rise) model_serve();
      1: if (m_cnt == SERVE - 1) m_state = 2; else m_cnt++;
      2: model_play(opl, opr);
      3: begin
        if (m_left_scored) m_sl++; else m_sr++;
        if ((m_left_scored ? m_sl : m_sr) == WIN) m_state = 4;
        else begin m_dx = m_left_scored ? 1 : 0; model_serve(); end
      end
      default: if (rise) begin m_sl = 0; m_sr = 0; model_serve(); end
    endcase
  endfunction

  function automatic logic [52:0] model_snap();
    return {10'(m_x), 10'(m_y), 10'(m_pl), 10'(m_pr), 4'(m_sl), 4'(m_sr), 3'(m_state),
            (m_state == 2), (m_state == 4)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    if (reset) model_reset();
    else model_step(start, left_in, right_in);
    #1;
    check("frame", {11'd0, dut_snap}, {11'd0, model_snap()});
  endtask

  task automatic ai_right();
    int c = int'(ball_y) - 20;
    int p = int'(pad_r_y);
    right_in = (p > c + 2) ? 2'b10 : (p + 2 < c) ? 2'b01 : 2'b00;
  endtask

  task automatic avoid_left();
    left_in = (ball_y < 10'd245) ? 2'b01 : 2'b10;
  endtask

  typedef struct {
    logic [1:0] l;
    logic [1:0] r;
    int         n;
    int         pl;
    int         pr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, serve_frames;
    vecs[0] = '{2'b10, 2'b00,  50,  50, 225};
    vecs[1] = '{2'b11, 2'b10,   3,  50, 213};
    vecs[2] = '{2'b01, 2'b11, 100, 400, 213};
    vecs[3] = '{2'b00, 2'b01, 100, 400, 400};
    vecs[4] = '{2'b10, 2'b10,   1, 396, 396};
    vecs[5] = '{2'b01, 2'b01,   1, 400, 400};

    model_reset();
    reset = 1'b1; start = 1'b0; left_in = 2'b00; right_in = 2'b00;
    tick();
    check("reset_state", {11'd0, dut_snap}, {11'd0, RESET_SNAP});
    @(negedge frame_clk) reset = 1'b0;
    tick();
    check("idle_hold", {11'd0, dut_snap}, {11'd0, RESET_SNAP});

    for (int i = 0; i < 6; i++) begin
      left_in = vecs[i].l; right_in = vecs[i].r;
      for (int j = 0; j < vecs[i].n; j++) tick();
      check("vec_pad_l", 64'(pad_l_y), 64'(vecs[i].pl));
      check("vec_pad_r", 64'(pad_r_y), 64'(vecs[i].pr));
      check("vec_state", 64'(state), 64'd0);
    end

    // Serve timing and first PLAY frame
    left_in = 2'b00; right_in = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    serve_frames = (state == 3'd1) ? 1 : 0;
    k = 0;
    while (state == 3'd1 && k < 200) begin
      ai_right(); tick(); k++;
      if (state == 3'd1) serve_frames++;
    end
    check("serve_len", 64'(serve_frames), 64'd60);
    check("play_state", 64'(state), 64'd2);
    check("play_running", 64'(running), 64'd1);
    check("play_hold_xy", {ball_x, ball_y}, {10'd320, 10'd245});
    ai_right(); tick();
    check("play_f1_xy", {ball_x, ball_y}, {10'd318, 10'd247});

    // Floor bounce
    k = 0;
    while (ball_y != 10'd440 && k < 200) begin ai_right(); tick(); k++; end
    check("floor_clamp", 64'(ball_y), 64'd440);
    ai_right(); tick();
    check("floor_rebound", 64'(ball_y), 64'd438);

    // Left paddle parked at 400 returns the ball
    k = 0;
    while (ball_x != 10'd80 && k < 300) begin ai_right(); tick(); k++; end
    check("pad_l_hit", 64'(ball_x), 64'd80);
    ai_right(); tick();
    check("pad_l_rebound", 64'(ball_x), 64'd82);

    // Left paddle retreats to the top; ball is missed on the left
    left_in = 2'b10;
    k = 0;
    while (state != 3'd3 && k < 1000) begin ai_right(); tick(); k++; end
    check("point_state", 64'(state), 64'd3);
    check("point_score_before", {score_l, score_r}, {4'd0, 4'd0});
    ai_right(); tick();
    check("point_to_serve", 64'(state), 64'd1);
    check("point_score_r", {score_l, score_r}, {4'd0, 4'd1});
    check("point_recentre", {ball_x, ball_y}, {10'd320, 10'd245});

    // Play on until someone wins
    k = 0;
    while (state != 3'd4 && k < 30000) begin avoid_left(); ai_right(); tick(); k++; end
    check("over_state", 64'(state), 64'd4);
    check("over_flags", {running, game_over}, {1'b0, 1'b1});
    check("over_winner", 64'(score_l == 4'd9 || score_r == 4'd9), 64'd1);
    left_in = 2'b10; right_in = 2'b01;
    for (int j = 0; j < 5; j++) tick();
    check("over_frozen", 64'(state), 64'd4);

    // Held start from OVER triggers a single restart
    start = 1'b1;
    tick();
    check("restart_state", 64'(state), 64'd1);
    check("restart_scores", {score_l, score_r}, {4'd0, 4'd0});
    check("restart_ball", {ball_x, ball_y}, {10'd320, 10'd245});
    for (int j = 0; j < 3; j++) tick();
    start = 1'b0;
    for (int j = 0; j < 80; j++) begin avoid_left(); ai_right(); tick(); end
    check("pre_reset_running", 64'(running), 64'd1);

    // Asynchronous reset mid-frame
    #2 reset = 1'b1;
    #1;
    check("reset_async", {11'd0, dut_snap}, {11'd0, RESET_SNAP});
    model_reset();
    tick();
    @(negedge frame_clk) reset = 1'b0;

    // Random play against the model
    for (int j = 0; j < 3000; j++) begin
      start = ($urandom_range(0, 19) == 0);
      left_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) ai_right();
      else right_in = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
